// File: rtl/regfile_write_arbiter.sv
// Single write-port owner for the 32x32 integer register file: zero-scrub after
// reset or on request, then core/debug arbitration with a debug starvation guard.
module regfile_write_arbiter #(
  parameter int unsigned ADDR_W     = 5,
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned STARVE_LIM = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              core_wr_valid,
  output logic              core_wr_ready,
  input  logic [ADDR_W-1:0] core_wr_addr,
  input  logic [DATA_W-1:0] core_wr_data,
  input  logic              dbg_wr_valid,
  output logic              dbg_wr_ready,
  input  logic [ADDR_W-1:0] dbg_wr_addr,
  input  logic [DATA_W-1:0] dbg_wr_data,
  input  logic              scrub_start,
  output logic              busy,
  output logic              rf_we,
  output logic [ADDR_W-1:0] rf_wa,
  output logic [DATA_W-1:0] rf_wd
);

  localparam int unsigned CNT_W = 4;

  typedef enum logic {SCRUB, ACTIVE} state_e;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   scrub_cnt_q, scrub_cnt_d;
  logic [CNT_W-1:0]    starve_cnt_q, starve_cnt_d;
  logic                rf_we_q, rf_we_d;
  logic [ADDR_W-1:0]   rf_wa_q, rf_wa_d;
  logic [DATA_W-1:0]   rf_wd_q, rf_wd_d;
  logic                busy_q, busy_d;
  logic                open_c, starved_c, grant_dbg_c, grant_core_c;

  // Grants are only offered in ACTIVE and never in a cycle that requests a re-scrub
  assign open_c       = (state_q == ACTIVE) & ~scrub_start;
  assign starved_c    = (starve_cnt_q == CNT_W'(STARVE_LIM));
  assign grant_dbg_c  = open_c & dbg_wr_valid & (~core_wr_valid | starved_c);
  assign grant_core_c = open_c & core_wr_valid & ~grant_dbg_c;

  assign core_wr_ready = grant_core_c;
  assign dbg_wr_ready  = grant_dbg_c;
  assign busy          = busy_q;
  assign rf_we         = rf_we_q;
  assign rf_wa         = rf_wa_q;
  assign rf_wd         = rf_wd_q;

  // Next-state and registered-output logic
  always_comb begin
    state_d      = state_q;
    scrub_cnt_d  = scrub_cnt_q;
    starve_cnt_d = starve_cnt_q;
    rf_we_d      = 1'b0;
    rf_wa_d      = rf_wa_q;
    rf_wd_d      = rf_wd_q;
    busy_d       = busy_q;
    case (state_q)
      SCRUB: begin
        rf_we_d      = 1'b1;
        rf_wa_d      = scrub_cnt_q;
        rf_wd_d      = '0;
        scrub_cnt_d  = scrub_cnt_q + ADDR_W'(1);
        starve_cnt_d = '0;
        if (scrub_cnt_q == {ADDR_W{1'b1}}) begin
          state_d = ACTIVE;
          busy_d  = 1'b0;
        end
      end
      ACTIVE: begin
        if (scrub_start) begin
          state_d      = SCRUB;
          scrub_cnt_d  = ADDR_W'(1);
          busy_d       = 1'b1;
          starve_cnt_d = '0;
        end else begin
          if (grant_core_c) begin
            rf_we_d = |core_wr_addr;
            rf_wa_d = core_wr_addr;
            rf_wd_d = core_wr_data;
          end else if (grant_dbg_c) begin
            rf_we_d = |dbg_wr_addr;
            rf_wa_d = dbg_wr_addr;
            rf_wd_d = dbg_wr_data;
          end
          // Count lost arbitration cycles of a pending debug request, saturating
          if (dbg_wr_valid && !grant_dbg_c) begin
            if (!starved_c) starve_cnt_d = starve_cnt_q + CNT_W'(1);
          end else begin
            starve_cnt_d = '0;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= SCRUB;
      scrub_cnt_q  <= ADDR_W'(1);
      starve_cnt_q <= '0;
      rf_we_q      <= 1'b0;
      rf_wa_q      <= '0;
      rf_wd_q      <= '0;
      busy_q       <= 1'b1;
    end else begin
      state_q      <= state_d;
      scrub_cnt_q  <= scrub_cnt_d;
      starve_cnt_q <= starve_cnt_d;
      rf_we_q      <= rf_we_d;
      rf_wa_q      <= rf_wa_d;
      rf_wd_q      <= rf_wd_d;
      busy_q       <= busy_d;
    end
  end

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Self-checking bench for regfile_write_arbiter: expected port writes are queued
// as stimulus is driven and compared after the following clock edge.
module tb_regfile_write_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        core_wr_valid, core_wr_ready;
  logic [4:0]  core_wr_addr;
  logic [31:0] core_wr_data;
  logic        dbg_wr_valid, dbg_wr_ready;
  logic [4:0]  dbg_wr_addr;
  logic [31:0] dbg_wr_data;
  logic        scrub_start, busy, rf_we;
  logic [4:0]  rf_wa;
  logic [31:0] rf_wd;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct packed {
    logic        we;
    logic [4:0]  wa;
    logic [31:0] wd;
    logic        busy;
  } exp_t;
  exp_t exp_q[$];

  always #5 clk = ~clk;

  regfile_write_arbiter #(.ADDR_W(5), .DATA_W(32), .STARVE_LIM(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .core_wr_valid(core_wr_valid), .core_wr_ready(core_wr_ready),
    .core_wr_addr(core_wr_addr), .core_wr_data(core_wr_data),
    .dbg_wr_valid(dbg_wr_valid), .dbg_wr_ready(dbg_wr_ready),
    .dbg_wr_addr(dbg_wr_addr), .dbg_wr_data(dbg_wr_data),
    .scrub_start(scrub_start), .busy(busy),
    .rf_we(rf_we), .rf_wa(rf_wa), .rf_wd(rf_wd)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  // One clock: readies checked before the edge, queued write checked after it
  task automatic step(input logic cr, input logic dr, input logic we,
                      input logic [4:0] wa, input logic [31:0] wd, input logic bsy);
    exp_t e;
    @(negedge clk);
    check("core_ready", 32'(core_wr_ready), 32'(cr));
    check("dbg_ready", 32'(dbg_wr_ready), 32'(dr));
    exp_q.push_back('{we: we, wa: wa, wd: wd, busy: bsy});
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    check("rf_we", 32'(rf_we), 32'(e.we));
    check("rf_wa", 32'(rf_wa), 32'(e.wa));
    check("rf_wd", rf_wd, e.wd);
    check("busy", 32'(busy), 32'(e.busy));
  endtask

  task automatic scrub_run(input int last);
    for (int i = 1; i <= last; i++)
      step(1'b0, 1'b0, 1'b1, 5'(i), 32'h0, i != 31);
  endtask

  initial begin
    rst_n = 1'b0; core_wr_valid = 1'b0; dbg_wr_valid = 1'b0; scrub_start = 1'b0;
    core_wr_addr = '0; core_wr_data = '0; dbg_wr_addr = '0; dbg_wr_data = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_we", 32'(rf_we), 32'h0);
    check("rst_busy", 32'(busy), 32'h1);
    check("rst_wa", 32'(rf_wa), 32'h0);
    check("rst_core_ready", 32'(core_wr_ready), 32'h0);
    rst_n = 1'b1;

    // Initial scrub of x1..x31, then one idle cycle
    scrub_run(31);
    step(1'b0, 1'b0, 1'b0, 5'd31, 32'h0, 1'b0);

    // Core write, then the port goes idle and holds address/data
    core_wr_valid = 1'b1; core_wr_addr = 5'd5; core_wr_data = 32'hDEADBEEF;
    step(1'b1, 1'b0, 1'b1, 5'd5, 32'hDEADBEEF, 1'b0);
    core_wr_valid = 1'b0;
    step(1'b0, 1'b0, 1'b0, 5'd5, 32'hDEADBEEF, 1'b0);

    // Write to x0 handshakes but never asserts rf_we
    core_wr_valid = 1'b1; core_wr_addr = 5'd0; core_wr_data = 32'h12345678;
    step(1'b1, 1'b0, 1'b0, 5'd0, 32'h12345678, 1'b0);
    core_wr_valid = 1'b0;

    // Debug alone is granted immediately
    dbg_wr_valid = 1'b1; dbg_wr_addr = 5'd9; dbg_wr_data = 32'h0BADF00D;
    step(1'b0, 1'b1, 1'b1, 5'd9, 32'h0BADF00D, 1'b0);

    // Contention: core wins four cycles, debug on the fifth, core again on the sixth
    dbg_wr_addr = 5'd7; dbg_wr_data = 32'hA5A5A5A5;
    core_wr_valid = 1'b1; core_wr_addr = 5'd3;
    for (int k = 0; k < 4; k++) begin
      core_wr_data = 32'hC000_0000 + 32'(k);
      step(1'b1, 1'b0, 1'b1, 5'd3, 32'hC000_0000 + 32'(k), 1'b0);
    end
    core_wr_data = 32'hC000_0010;
    step(1'b0, 1'b1, 1'b1, 5'd7, 32'hA5A5A5A5, 1'b0);
    dbg_wr_valid = 1'b0;
    step(1'b1, 1'b0, 1'b1, 5'd3, 32'hC000_0010, 1'b0);

    // Re-scrub request beats a pending core write; core served afterwards
    core_wr_addr = 5'd12; core_wr_data = 32'h11112222; scrub_start = 1'b1;
    step(1'b0, 1'b0, 1'b0, 5'd3, 32'hC000_0010, 1'b1);
    scrub_start = 1'b0;
    scrub_run(31);
    step(1'b1, 1'b0, 1'b1, 5'd12, 32'h11112222, 1'b0);
    core_wr_valid = 1'b0;

    // Asynchronous reset in the middle of a scrub, then a full restart from x1
    scrub_start = 1'b1;
    step(1'b0, 1'b0, 1'b0, 5'd12, 32'h11112222, 1'b1);
    scrub_start = 1'b0;
    scrub_run(9);
    rst_n = 1'b0;
    #1;
    check("midrst_we", 32'(rf_we), 32'h0);
    check("midrst_busy", 32'(busy), 32'h1);
    check("midrst_wa", 32'(rf_wa), 32'h0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    scrub_run(31);
    step(1'b0, 1'b0, 1'b0, 5'd31, 32'h0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
